// File: rtl/osc_gen_pkg.sv
// osc_gen_pkg: shared widths, reset defaults and value types for the
// PT2262/PT2272 oscillator (osc_gen) and its bit-tick divider (osc_tick_div).
package osc_gen_pkg;
    localparam int CNT_W_DEF    = 16;   // half-period counter width
    localparam int DIV_W_DEF    = 8;    // bit-tick divisor width
    localparam int DEFAULT_HALF = 125;  // 126 clk per half -> ~11.9 kHz at 3 MHz
    localparam int DEFAULT_DIV  = 32;   // osc periods per bit_tick

    typedef logic [CNT_W_DEF-1:0] osc_cnt_t;
    typedef logic [DIV_W_DEF-1:0] osc_div_t;
endpackage

// File: rtl/osc_tick_div.sv
// osc_tick_div: counts osc rising edges and emits bit_tick on every div-th one.
// Ports:
//   clk, rst  clock, async active-high reset
//   rise_i    the osc rise being registered this clk (next-state strobe)
//   clear_i   restart the period count (divisor change or idle)
//   div_i     periods per tick; 0 disables the tick and parks the count at 0
//   tick_o    registered tick, aligned with the registered osc_rise
module osc_tick_div
    import osc_gen_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rise_i,
    input  logic             clear_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);
    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] pcnt_q, pcnt_d;
    logic             tick_q, tick_d;

    // Clear beats a coincident rise: the rise that applies a new divisor
    // is not counted, so counting under the new divisor starts fresh.
    always_comb begin
        pcnt_d = pcnt_q;
        tick_d = 1'b0;
        if (clear_i) begin
            pcnt_d = '0;
        end else if (rise_i && (div_i != '0)) begin
            if (pcnt_q == div_i - ONE) begin
                tick_d = 1'b1;
                pcnt_d = '0;
            end else begin
                pcnt_d = pcnt_q + ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q <= '0;
            tick_q <= 1'b0;
        end else begin
            pcnt_q <= pcnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;
endmodule

// File: rtl/osc_gen.sv
// osc_gen: runtime-programmable square-wave oscillator. Divides clk into osc
// with registered rise/fall strobes and a bit_tick every bit_div osc periods.
// New divisors are captured into shadow registers by load and applied only at
// a half-period boundary (or while idle), so no runt pulses are produced.
// Build option: define OSC_GEN_ASYM_EN to add a separately programmable
// low-phase terminal count (low_period); otherwise both phases use half_period.
// Ports:
//   clk, rst      clock, async active-high reset
//   en            run enable; idle holds osc high
//   load          1-clk strobe capturing half_period/bit_div (/low_period)
//   half_period   terminal count; high phase lasts half_period+1 clks
//   low_period    (OSC_GEN_ASYM_EN only) low-phase terminal count
//   bit_div       osc periods per bit_tick; 0 disables bit_tick
//   osc           registered oscillator output
//   osc_rise      1-clk pulse in the cycle osc becomes 1
//   osc_fall      1-clk pulse in the cycle osc becomes 0
//   bit_tick      1-clk pulse with the osc_rise closing each bit_div-th period
//   pending       shadow holds values not yet applied
module osc_gen
    import osc_gen_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEF,
    parameter int DIV_W        = DIV_W_DEF,
    parameter int DEFAULT_HALF = osc_gen_pkg::DEFAULT_HALF,
    parameter int DEFAULT_DIV  = osc_gen_pkg::DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] half_period,
`ifdef OSC_GEN_ASYM_EN
    input  logic [CNT_W-1:0] low_period,
`endif
    input  logic [DIV_W-1:0] bit_div,
    output logic             osc,
    output logic             osc_rise,
    output logic             osc_fall,
    output logic             bit_tick,
    output logic             pending
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] HP_RST  = CNT_W'(DEFAULT_HALF);
    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d, hp_q, hp_d, hp_sh_q, hp_sh_d;
    logic [DIV_W-1:0] div_q, div_d, div_sh_q, div_sh_d;
    logic             osc_q, osc_d, rise_q, rise_d, fall_q, fall_d, pend_q, pend_d;
    logic [CNT_W-1:0] term;
    logic             wrap, apply, clear;

`ifdef OSC_GEN_ASYM_EN
    logic [CNT_W-1:0] lp_q, lp_d, lp_sh_q, lp_sh_d;
    assign term = osc_q ? hp_q : lp_q;
`else
    assign term = hp_q;
`endif

    assign wrap  = en && (cnt_q == term);
    // New values may take effect at any half-period boundary, or at once
    // while idle since there is no waveform to corrupt.
    assign apply = wrap || !en;
    assign clear = !en || (wrap && (load || pend_q));

    always_comb begin
        cnt_d    = cnt_q;
        osc_d    = osc_q;
        hp_d     = hp_q;
        div_d    = div_q;
        hp_sh_d  = hp_sh_q;
        div_sh_d = div_sh_q;
        pend_d   = pend_q;
`ifdef OSC_GEN_ASYM_EN
        lp_d     = lp_q;
        lp_sh_d  = lp_sh_q;
`endif
        if (apply) begin
            // A load landing on an apply point bypasses the shadow.
            if (load) begin
                hp_d  = half_period;
                div_d = bit_div;
`ifdef OSC_GEN_ASYM_EN
                lp_d  = low_period;
`endif
            end else if (pend_q) begin
                hp_d  = hp_sh_q;
                div_d = div_sh_q;
`ifdef OSC_GEN_ASYM_EN
                lp_d  = lp_sh_q;
`endif
            end
            pend_d = 1'b0;
        end else if (load) begin
            hp_sh_d  = half_period;
            div_sh_d = bit_div;
`ifdef OSC_GEN_ASYM_EN
            lp_sh_d  = low_period;
`endif
            pend_d   = 1'b1;
        end

        if (!en) begin
            cnt_d = '0;
            osc_d = 1'b1;
        end else if (wrap) begin
            cnt_d = '0;
            osc_d = ~osc_q;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
        rise_d = wrap && !osc_q;
        fall_d = wrap && osc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            osc_q    <= 1'b1;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            pend_q   <= 1'b0;
            hp_q     <= HP_RST;
            hp_sh_q  <= HP_RST;
            div_q    <= DIV_RST;
            div_sh_q <= DIV_RST;
        end else begin
            cnt_q    <= cnt_d;
            osc_q    <= osc_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            pend_q   <= pend_d;
            hp_q     <= hp_d;
            hp_sh_q  <= hp_sh_d;
            div_q    <= div_d;
            div_sh_q <= div_sh_d;
        end
    end

`ifdef OSC_GEN_ASYM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lp_q    <= HP_RST;
            lp_sh_q <= HP_RST;
        end else begin
            lp_q    <= lp_d;
            lp_sh_q <= lp_sh_d;
        end
    end
`endif

    osc_tick_div #(.DIV_W(DIV_W)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .rise_i  (rise_d),
        .clear_i (clear),
        .div_i   (div_q),
        .tick_o  (bit_tick)
    );

    assign osc      = osc_q;
    assign osc_rise = rise_q;
    assign osc_fall = fall_q;
    assign pending  = pend_q;
endmodule

// File: tb/tb_osc_gen.sv
// tb_osc_gen: directed scenarios with hand-computed timings, then randomized
// traffic; a phase-length model checks every output on every cycle.
module tb_osc_gen;
    import osc_gen_pkg::*;

    logic     clk = 1'b0;
    logic     rst, en, load;
    osc_cnt_t half_period, low_period;
    osc_div_t bit_div;
    logic     osc, osc_rise, osc_fall, bit_tick, pending;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    osc_gen dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .load        (load),
        .half_period (half_period),
`ifdef OSC_GEN_ASYM_EN
        .low_period  (low_period),
`endif
        .bit_div     (bit_div),
        .osc         (osc),
        .osc_rise    (osc_rise),
        .osc_fall    (osc_fall),
        .bit_tick    (bit_tick),
        .pending     (pending)
    );

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: each phase lasts (terminal+1) clks; rises are counted modulo div.
    int m_hp, m_lp, m_div, s_hp, s_lp, s_div, m_el, m_nr;
    bit m_pend, m_osc, m_rise, m_fall, m_tick;

    task automatic m_reset();
        m_hp = DEFAULT_HALF; m_lp = DEFAULT_HALF; m_div = DEFAULT_DIV;
        s_hp = m_hp; s_lp = m_lp; s_div = m_div;
        m_pend = 0; m_osc = 1; m_rise = 0; m_fall = 0; m_tick = 0;
        m_el = 0; m_nr = 0;
    endtask

    function automatic int m_low();
`ifdef OSC_GEN_ASYM_EN
        return m_lp;
`else
        return m_hp;
`endif
    endfunction

    task automatic m_take(input bit from_inputs);
        if (from_inputs) begin
            m_hp = int'(half_period); m_lp = int'(low_period); m_div = int'(bit_div);
        end else begin
            m_hp = s_hp; m_lp = s_lp; m_div = s_div;
        end
    endtask

    task automatic m_step();
        int len;
        bit upd;
        m_rise = 0; m_fall = 0; m_tick = 0;
        if (!en) begin
            if (load) m_take(1); else if (m_pend) m_take(0);
            m_pend = 0; m_osc = 1; m_el = 0; m_nr = 0;
        end else begin
            m_el++;
            len = (m_osc ? m_hp : m_low()) + 1;
            if (m_el == len) begin
                m_osc = !m_osc;
                m_el = 0;
                m_rise = m_osc;
                m_fall = !m_osc;
                upd = load || m_pend;
                if (load) m_take(1); else if (m_pend) m_take(0);
                m_pend = 0;
                if (upd) m_nr = 0;
                else if (m_rise && m_div != 0) begin
                    m_nr++;
                    if (m_nr == m_div) begin m_tick = 1; m_nr = 0; end
                end
            end else if (load) begin
                s_hp = int'(half_period); s_lp = int'(low_period); s_div = int'(bit_div);
                m_pend = 1;
            end
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) m_reset(); else m_step();
        end
    end

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (rst === 1'b0) begin
            check("osc",      int'(osc),      int'(m_osc));
            check("osc_rise", int'(osc_rise), int'(m_rise));
            check("osc_fall", int'(osc_fall), int'(m_fall));
            check("bit_tick", int'(bit_tick), int'(m_tick));
            check("pending",  int'(pending),  int'(m_pend));
        end
    end

    // which: 0 = osc_fall, 1 = osc_rise, 2 = bit_tick. n = clks waited, -1 on timeout.
    task automatic wait_ev(input int which, input int budget, output int n);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if ((which == 0 && osc_fall) || (which == 1 && osc_rise) ||
                (which == 2 && bit_tick)) break;
            if (n >= budget) begin n = -1; break; end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, r, t;
        rst = 1'b1; en = 1'b0; load = 1'b0;
        half_period = '0; low_period = '0; bit_div = '0;
        repeat (3) @(negedge clk);
        check("rst_osc", int'(osc), 1);
        check("rst_strobes", int'({osc_rise, osc_fall, bit_tick}), 0);
        check("rst_pending", int'(pending), 0);
        rst = 1'b0;
        @(negedge clk);

        // Defaults: fall 126 clks after enable, rise 126 later, tick at 8064.
        en = 1'b1;
        wait_ev(0, 300, n);   check("t1_first_fall", n, 126);
        wait_ev(1, 300, n);   check("t1_first_rise", n, 126);
        wait_ev(2, 9000, n);  check("t1_tick_after_rise1", n, 8064 - 252);
        wait_ev(1, 300, n);   check("t1_period", n, 252);

        // Load hp=3 mid half-period: old half completes, then 4-clk halves.
        repeat (50) @(negedge clk);
        check("t2_pend_before", int'(pending), 0);
        load = 1'b1; half_period = 16'd3; bit_div = 8'd32;
        @(negedge clk);
        load = 1'b0;
        check("t2_pend_set", int'(pending), 1);
        wait_ev(0, 300, n);   check("t2_old_half", n, 75);
        check("t2_pend_clr", int'(pending), 0);
        wait_ev(1, 20, n);    check("t2_new_half", n, 4);

        // Load hp=0 on the wrap edge: direct apply, toggling every clk.
        repeat (3) @(negedge clk);
        load = 1'b1; half_period = 16'd0;
        @(negedge clk);
        load = 1'b0;
        check("t3_wrap_fall", int'(osc_fall), 1);
        check("t3_no_pend", int'(pending), 0);
        @(negedge clk);
        check("t3_rise_next", int'(osc_rise), 1);
        @(negedge clk);
        check("t3_fall_next", int'(osc_fall), 1);

        // bit_div=0: no ticks over 1000 periods; then bit_div=2.
        load = 1'b1; bit_div = 8'd0;
        @(negedge clk);
        load = 1'b0;
        t = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (bit_tick) t++;
        end
        check("t4_no_ticks", t, 0);
        load = 1'b1; bit_div = 8'd2;
        @(negedge clk);
        load = 1'b0;
        check("t4_apply_no_tick", int'(bit_tick), 0);
        r = 0; n = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (osc_rise) r++;
            if (bit_tick) begin n = r; break; end
        end
        check("t4_tick_on_rise", n, 2);

        // Drop en while osc low: osc returns high with no rise strobe.
        load = 1'b1; half_period = 16'd3;
        @(negedge clk);
        load = 1'b0;
        wait_ev(0, 20, n);    check("t5_sync", int'(n > 0), 1);
        en = 1'b0;
        @(negedge clk);
        check("t5_osc_high", int'(osc), 1);
        check("t5_quiet", int'({osc_rise, osc_fall, bit_tick}), 0);
        repeat (5) @(negedge clk);
        en = 1'b1;
        wait_ev(0, 20, n);    check("t5_reen_fall", n, 4);

        // Async reset with a pending load: shadow discarded, defaults resume.
        @(negedge clk);
        load = 1'b1; half_period = 16'd7;
        @(negedge clk);
        load = 1'b0;
        check("t6_pend", int'(pending), 1);
        #2 rst = 1'b1;
        #1;
        check("t6_async_osc", int'(osc), 1);
        check("t6_async_pend", int'(pending), 0);
        @(negedge clk);
        rst = 1'b0;
        wait_ev(0, 300, n);   check("t6_default_fall", n, 126);

`ifdef OSC_GEN_ASYM_EN
        load = 1'b1; half_period = 16'd9; low_period = 16'd4;
        @(negedge clk);
        load = 1'b0;
        wait_ev(1, 300, n);   check("t7_apply", int'(n > 0), 1);
        wait_ev(0, 50, n);    check("t7_high", n, 10);
        wait_ev(1, 50, n);    check("t7_low", n, 5);
`endif

        // Randomized traffic with occasional async reset pulses.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            en          = ($urandom_range(0, 19) != 0);
            load        = ($urandom_range(0, 9) == 0);
            half_period = 16'($urandom_range(0, 6));
            low_period  = 16'($urandom_range(0, 6));
            bit_div     = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 499) == 0) begin
                #2 rst = 1'b1;
                #2 rst = 1'b0;
            end
        end
        load = 1'b0;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
